instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 33 +++
 rtl/instruction_fetch_size_decoder.sv | 25 ++
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction-size type and the opcodes that have a non-default length.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_OP1 = 3'd1,
    FETCH_OP2 = 3'd2,
    ISSUE     = 3'd3,
    ADVANCE   = 3'd4
  } fetch_state_e;

  // Instruction length in memory words; only 1..3 are ever produced.
  typedef logic [1:0] instr_size_t;

  localparam instr_size_t SIZE_1 = 2'd1;
  localparam instr_size_t SIZE_2 = 2'd2;
  localparam instr_size_t SIZE_3 = 2'd3;

  // Single-word opcode.
  localparam logic [7:0] OPC_83 = 8'h83;

  // Two-word opcodes; every other opcode is three words long.
  localparam logic [7:0] OPC_78 = 8'h78;
  localparam logic [7:0] OPC_80 = 8'h80;
  localparam logic [7:0] OPC_C0 = 8'hC0;
  localparam logic [7:0] OPC_81 = 8'h81;
  localparam logic [7:0] OPC_82 = 8'h82;
  localparam logic [7:0] OPC_84 = 8'h84;
  localparam logic [7:0] OPC_85 = 8'h85;
  localparam logic [7:0] OPC_87 = 8'h87;

endpackage

// File: rtl/instruction_fetch_size_decoder.sv
// Combinational opcode-to-length decoder. Kept as its own block so the
// program counter's increment logic can reuse exactly the same table.
module instr_size_decoder
  import instruction_fetch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] opcode,
  output logic [1:0]        size
);

  // Look up the instruction length; anything not listed is three words.
  always_comb begin
    size = SIZE_3;
    if (opcode == DATA_W'(OPC_83)) begin
      size = SIZE_1;
    end else if ((opcode == DATA_W'(OPC_78)) || (opcode == DATA_W'(OPC_80)) ||
                 (opcode == DATA_W'(OPC_C0)) || (opcode == DATA_W'(OPC_81)) ||
                 (opcode == DATA_W'(OPC_82)) || (opcode == DATA_W'(OPC_84)) ||
                 (opcode == DATA_W'(OPC_85)) || (opcode == DATA_W'(OPC_87))) begin
      size = SIZE_2;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads a 1..3 word instruction starting at pc,
// presents it to decode, then strobes pc_load for one cycle.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  input  logic              ir_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic              instr_valid,
  output logic              pc_load
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand1_q, operand1_d;
  logic [DATA_W-1:0] operand2_q, operand2_d;
  logic [DATA_W-1:0] size_opcode;
  logic [1:0]        size;

  // Size the word arriving from memory while fetching the opcode, otherwise the held opcode.
  always_comb begin
    size_opcode = (state_q == FETCH_OP) ? mem_data : opcode_q;
  end

  instr_size_decoder #(
    .DATA_W (DATA_W)
  ) u_size_decoder (
    .opcode (size_opcode),
    .size   (size)
  );

  // Next-state, capture and output decode; a fetch state only advances on a ready memory cycle.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    operand1_d  = operand1_q;
    operand2_d  = operand2_q;
    mem_req     = 1'b0;
    mem_addr    = pc;
    instr_valid = 1'b0;
    pc_load     = 1'b0;
    case (state_q)
      FETCH_OP: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          opcode_d   = mem_data;
          operand1_d = '0;
          operand2_d = '0;
          state_d    = (size == SIZE_1) ? ISSUE : FETCH_OP1;
        end
      end
      FETCH_OP1: begin
        mem_req  = 1'b1;
        mem_addr = pc + ADDR_W'(1);
        if (mem_ready) begin
          operand1_d = mem_data;
          state_d    = (size == SIZE_2) ? ISSUE : FETCH_OP2;
        end
      end
      FETCH_OP2: begin
        mem_req  = 1'b1;
        mem_addr = pc + ADDR_W'(2);
        if (mem_ready) begin
          operand2_d = mem_data;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (ir_ready) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        pc_load = 1'b1;
        state_d = FETCH_OP;
      end
      default: begin
        state_d = FETCH_OP;
      end
    endcase
  end

  // State and instruction registers; reset drops any partial instruction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH_OP;
      opcode_q   <= '0;
      operand1_q <= '0;
      operand2_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      operand1_q <= operand1_d;
      operand2_q <= operand2_d;
    end
  end

  assign opcode   = opcode_q;
  assign operand1 = operand1_q;
  assign operand2 = operand2_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A behavioural model derives the
// expected instruction, address sequence and timing from the memory image.
module tb_instruction_fetch;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] pc;
  logic [7:0] memData;
  logic       memReady;
  logic       irReady;
  logic       memReq;
  logic [5:0] memAddr;
  logic [7:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic       instrValid;
  logic       pcLoad;

  logic [7:0] mem [64];
  int nAsserts = 0;
  int nFails   = 0;

  localparam logic [7:0] INTERESTING_OPS [10] =
    '{8'h78, 8'h80, 8'hC0, 8'h81, 8'h82, 8'h84, 8'h85, 8'h87, 8'h83, 8'h01};

  instruction_fetch #(
    .ADDR_W (6),
    .DATA_W (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc          (pc),
    .mem_data    (memData),
    .mem_ready   (memReady),
    .ir_ready    (irReady),
    .mem_req     (memReq),
    .mem_addr    (memAddr),
    .opcode      (opcode),
    .operand1    (operand1),
    .operand2    (operand2),
    .instr_valid (instrValid),
    .pc_load     (pcLoad)
  );

  // Program memory answers combinationally from the requested address.
  assign memData = mem[memAddr];

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Reference instruction length straight from the opcode table.
  function automatic int refSize(input logic [7:0] op);
    if (op == 8'h83) return 1;
    if (op inside {8'h78, 8'h80, 8'hC0, 8'h81, 8'h82, 8'h84, 8'h85, 8'h87}) return 2;
    return 3;
  endfunction

  // One comparison: counts it, and reports and counts a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one instruction from startPc until its pc_load strobe and checks it.
  // mode 0: always ready, 1: random readies, 2: memory stalls 3 cycles on the
  // first operand, 3: decode stalls 4 cycles.
  task automatic applyStimulus(input logic [5:0] startPc, input int mode, output int sizeOut);
    int         sz;
    int         cycles;
    int         validCycles;
    int         irLow;
    int         bad;
    int         stalls;
    bit         done;
    bit         first;
    logic [5:0] addrs[$];
    logic [7:0] eOp, eOp1, eOp2;
    logic [5:0] a1, a2;
    pc = startPc;
    a1 = startPc + 6'd1;
    a2 = startPc + 6'd2;
    sz = refSize(mem[startPc]);
    eOp  = mem[startPc];
    eOp1 = (sz >= 2) ? mem[a1] : 8'h00;
    eOp2 = (sz == 3) ? mem[a2] : 8'h00;
    cycles = 0; validCycles = 0; irLow = 0; bad = 0; stalls = 0;
    done = 1'b0; first = 1'b1;
    while (!done && cycles < 200) begin
      @(negedge clock);
      case (mode)
        0: begin memReady = 1'b1; irReady = 1'b1; end
        1: begin memReady = ($urandom % 4) != 0; irReady = ($urandom % 3) != 0; end
        2: begin memReady = !(addrs.size() == 1 && stalls < 3); irReady = 1'b1; end
        default: begin memReady = 1'b1; irReady = (validCycles >= 4); end
      endcase
      #1;
      cycles++;
      if (first) begin
        checkOutput("first_mem_req", memReq, 1);
        checkOutput("first_mem_addr", memAddr, startPc);
        checkOutput("first_pc_load_low", pcLoad, 0);
        first = 1'b0;
      end
      if (mode == 2 && memReq && !memReady && addrs.size() == 1) begin
        stalls++;
        if (memAddr !== a1 || operand1 !== 8'h00) bad++;
      end
      if (memReq && memReady) addrs.push_back(memAddr);
      if (instrValid) begin
        validCycles++;
        if (!irReady) irLow++;
        if (opcode !== eOp || operand1 !== eOp1 || operand2 !== eOp2 ||
            memReq !== 1'b0 || pcLoad !== 1'b0) bad++;
      end
      if (pcLoad) begin
        done = 1'b1;
        checkOutput("advance_valid_low", instrValid, 0);
        checkOutput("advance_opcode", opcode, eOp);
      end
    end
    checkOutput("pc_load_seen", done, 1);
    checkOutput("word_count", addrs.size(), sz);
    for (int i = 0; i < addrs.size() && i < sz; i++) begin
      logic [5:0] ea;
      ea = startPc + 6'(i);
      checkOutput("fetch_addr", addrs[i], ea);
    end
    checkOutput("opcode", opcode, eOp);
    checkOutput("operand1", operand1, eOp1);
    checkOutput("operand2", operand2, eOp2);
    checkOutput("valid_cycles", validCycles, irLow + 1);
    checkOutput("issue_stable", bad, 0);
    if (mode == 0) checkOutput("cycle_count", cycles, sz + 2);
    if (mode == 2) checkOutput("mem_stalls", stalls, 3);
    if (mode == 3) checkOutput("issue_hold", validCycles, 5);
    sizeOut = sz;
  endtask

  // Directed scenarios, an abandoned fetch under reset, then a random program walk.
  initial begin
    int sz;
    bit hit;
    reset_n  = 1'b0;
    memReady = 1'b0;
    irReady  = 1'b0;
    pc       = 6'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

    #12;
    checkOutput("reset_opcode", opcode, 0);
    checkOutput("reset_operand1", operand1, 0);
    checkOutput("reset_operand2", operand2, 0);
    checkOutput("reset_valid", instrValid, 0);
    checkOutput("reset_pc_load", pcLoad, 0);
    @(negedge clock);
    #3 reset_n = 1'b1;

    $display("[TB] single-word instruction at pc 0");
    mem[0] = 8'h83;
    applyStimulus(6'd0, 0, sz);

    $display("[TB] two-word instruction at pc 10");
    mem[10] = 8'h80;
    mem[11] = 8'h55;
    applyStimulus(6'd10, 0, sz);

    $display("[TB] three-word instruction wrapping past address 63");
    mem[63] = 8'h01;
    mem[0]  = 8'hAA;
    mem[1]  = 8'hBB;
    applyStimulus(6'd63, 0, sz);

    $display("[TB] memory stall on first operand");
    mem[20] = 8'h01;
    applyStimulus(6'd20, 2, sz);

    $display("[TB] decode stall in issue");
    mem[30] = 8'h81;
    applyStimulus(6'd30, 3, sz);

    $display("[TB] reset during third word fetch");
    mem[40] = 8'h01;
    mem[41] = 8'h5A;
    pc  = 6'd40;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clock);
      memReady = 1'b1;
      irReady  = 1'b1;
      #1;
      if (memReq && memAddr == 6'd42) hit = 1'b1;
    end
    checkOutput("reached_third_fetch", hit, 1);
    memReady = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abort_opcode", opcode, 0);
    checkOutput("abort_operand1", operand1, 0);
    checkOutput("abort_operand2", operand2, 0);
    checkOutput("abort_valid", instrValid, 0);
    checkOutput("abort_pc_load", pcLoad, 0);
    checkOutput("abort_mem_addr", memAddr, 6'd40);
    @(posedge clock);
    #1;
    checkOutput("abort_hold_pc_load", pcLoad, 0);
    @(negedge clock);
    #3 reset_n = 1'b1;
    applyStimulus(6'd40, 0, sz);

    $display("[TB] random program walk");
    pc = 6'd40 + 6'(sz);
    for (int i = 0; i < 40; i++) begin
      logic [5:0] nextPc;
      if ($urandom % 2) mem[pc] = INTERESTING_OPS[$urandom_range(0, 9)];
      applyStimulus(pc, (i % 2 == 0) ? 0 : 1, sz);
      nextPc = pc + 6'(sz);
      pc = nextPc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
